// File: rtl/fsm_pos_edge.sv
// ============================================================================
// Module   : fsm_pos_edge
// Brief    : Rising-edge detector pair on one input: a Mealy flag that fires
//            within the same cycle and a Moore flag that is a registered pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fsm_pos_edge_mealy (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_dout
);
    localparam logic [0:0] c_ST_ZERO = 1'b0;
    localparam logic [0:0] c_ST_ONE  = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_next;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= c_ST_ZERO;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = c_ST_ZERO;
        case (r_state)
            c_ST_ZERO: w_next = i_din ? c_ST_ONE : c_ST_ZERO;
            c_ST_ONE:  w_next = i_din ? c_ST_ONE : c_ST_ZERO;
            default:   w_next = c_ST_ZERO;
        endcase
    end

    // Gated by reset so the flag is defined low even before the state settles.
    always_comb begin
        o_dout = i_rst & (r_state == c_ST_ZERO) & i_din;
    end

endmodule

module fsm_pos_edge_moore (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_dout
);
    localparam logic [1:0] c_ST_ZERO = 2'b00;
    localparam logic [1:0] c_ST_EDGE = 2'b01;
    localparam logic [1:0] c_ST_ONE  = 2'b10;

    logic [1:0] r_state;
    logic [1:0] w_next;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= c_ST_ZERO;
        end else begin
            r_state <= w_next;
        end
    end

    // The spare encoding 2'b11 falls through to ZERO.
    always_comb begin
        w_next = c_ST_ZERO;
        case (r_state)
            c_ST_ZERO: w_next = i_din ? c_ST_EDGE : c_ST_ZERO;
            c_ST_EDGE: w_next = i_din ? c_ST_ONE  : c_ST_ZERO;
            c_ST_ONE:  w_next = i_din ? c_ST_ONE  : c_ST_ZERO;
            default:   w_next = c_ST_ZERO;
        endcase
    end

    always_comb begin
        o_dout = (r_state == c_ST_EDGE);
    end

endmodule

module fsm_pos_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout_mealy,
    output logic dout_moore
);
    fsm_pos_edge_mealy u_mealy (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_din  (din),
        .o_dout (dout_mealy)
    );

    fsm_pos_edge_moore u_moore (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_din  (din),
        .o_dout (dout_moore)
    );

endmodule

`default_nettype wire

// File: tb/tb_fsm_pos_edge.sv
// ============================================================================
// Module   : tb_fsm_pos_edge
// Brief    : Directed and randomized checks of fsm_pos_edge against an
//            edge-rule reference model (previous sample 0, current sample 1).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fsm_pos_edge;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b0;
    logic dout_mealy;
    logic dout_moore;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: last sampled din since reset, and the registered flag.
    bit m_valid = 1'b0;
    bit m_last  = 1'b0;
    bit m_moore = 1'b0;
    int cnt_me  = 0;
    int cnt_mo  = 0;

    fsm_pos_edge dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .dout_mealy (dout_mealy),
        .dout_moore (dout_moore)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_cnt(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs == exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock cycle: drive on the falling edge, check mid-cycle and just
    // after the rising edge.
    task automatic step(input bit r, input bit d, input string tag);
        @(negedge clk);
        rst = r;
        din = d;
        #1;
        if (!r) begin
            chk({tag, ":mealy_in_rst"}, dout_mealy, 1'b0);
        end else if (m_valid) begin
            chk({tag, ":mealy_pre"}, dout_mealy, d & ~m_last);
            chk({tag, ":moore_pre"}, dout_moore, m_moore);
        end
        if (dout_mealy === 1'b1) cnt_me++;
        @(posedge clk);
        if (!r) begin
            m_valid = 1'b1;
            m_last  = 1'b0;
            m_moore = 1'b0;
        end else if (m_valid) begin
            m_moore = d & ~m_last;
            m_last  = d;
        end
        #1;
        if (m_valid) begin
            chk({tag, ":moore_post"}, dout_moore, m_moore);
            chk({tag, ":mealy_post"}, dout_mealy, r & d & ~m_last);
        end
        if (dout_moore === 1'b1) cnt_mo++;
    endtask

    initial begin
        string seq;
        bit    r;
        bit    d;

        // Reset, then release with din low.
        step(1'b0, 1'b0, "reset");
        step(1'b0, 1'b0, "reset");
        chk("reset_moore", dout_moore, 1'b0);
        step(1'b1, 1'b0, "release");
        step(1'b1, 1'b0, "release");

        // Spec sequence, bit 0 first.
        seq    = "001100101100010011010";
        cnt_me = 0;
        cnt_mo = 0;
        for (int i = 0; i < seq.len(); i++) begin
            step(1'b1, (seq[i] == "1"), "seq");
        end
        step(1'b1, 1'b0, "seq_tail");
        chk_cnt("seq_mealy_pulses", cnt_me, 6);
        chk_cnt("seq_moore_pulses", cnt_mo, 6);

        // Held high for five cycles after a zero.
        step(1'b1, 1'b0, "held");
        cnt_me = 0;
        cnt_mo = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "held");
        chk_cnt("held_mealy_pulses", cnt_me, 1);
        chk_cnt("held_moore_pulses", cnt_mo, 1);

        // Alternating 0101 for eight cycles.
        cnt_me = 0;
        cnt_mo = 0;
        for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 1), "alt");
        chk_cnt("alt_mealy_pulses", cnt_me, 4);
        chk_cnt("alt_moore_pulses", cnt_mo, 4);

        // Rising edge sampled under reset, then released with din still high.
        step(1'b1, 1'b0, "midrst");
        cnt_me = 0;
        cnt_mo = 0;
        step(1'b0, 1'b1, "midrst");
        chk("midrst_moore", dout_moore, 1'b0);
        step(1'b1, 1'b1, "midrst_rel");
        step(1'b1, 1'b1, "midrst_rel");
        chk_cnt("midrst_mealy_pulses", cnt_me, 1);
        chk_cnt("midrst_moore_pulses", cnt_mo, 1);

        // din high out of reset, then falling and held low.
        step(1'b0, 1'b0, "fall");
        cnt_me = 0;
        cnt_mo = 0;
        step(1'b1, 1'b1, "fall");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "fall");
        chk_cnt("fall_mealy_pulses", cnt_me, 1);
        chk_cnt("fall_moore_pulses", cnt_mo, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 19) != 0);
            d = 1'($urandom_range(0, 1));
            step(r, d, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
